// File: rtl/mod_counter.sv
// Purpose : parametrised synchronous modulo-MODULUS up/down counter with load, prescaler,
//           cascade terminal count (tc) and registered wrap pulse.
// Latency : count/wrap registered (1 cycle); tc combinational from state and inputs.
// Backpr. : none; en gates progress, load overrides stepping.
// Ports   : clk, reset (sync, active-low), en, up, load, load_val -> count, tc, wrap.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Top of the count range, truncated to the register width.
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_param
            $error("mod_counter: illegal WIDTH/MODULUS/PRESCALE combination");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_pre;
    logic             r_wrap;

    logic             w_tick;
    logic             w_at_term;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_tick    = en && (r_pre == PMAX);
    assign w_at_term = up ? (r_count == MAXV) : (r_count == '0);

    always_comb begin
        w_next = r_count;
        if (up) begin
            w_next = (r_count == MAXV) ? '0 : r_count + 1'b1;
        end else begin
            w_next = (r_count == '0) ? MAXV : r_count - 1'b1;
        end
    end

    // "<= MAXV" rather than "< MODULUS" keeps the compare at WIDTH bits even
    // when MODULUS == 2**WIDTH.
    assign w_load_clamped = (load_val <= MAXV) ? load_val : MAXV;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_pre   <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_pre   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (en) begin
                r_pre <= (r_pre == PMAX) ? '0 : PW'(r_pre + 1'b1);
            end
            if (w_tick) begin
                r_count <= w_next;
            end
            r_wrap <= w_tick && w_at_term;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    // Carry into the next digit: only a real step (not a load) out of the terminal value.
    assign tc    = reset && w_tick && !load && w_at_term;

endmodule
